// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   A DEPTH x WIDTH register file. It has one synchronous write port and two
//   combinational read ports. After reset, or after a runtime clear request,
//   a sequential clear engine zeroes one entry per clock. The engine raises
//   `ready` once every entry has been cleared. A per-register busy scoreboard
//   lets decode reserve a destination register. Writeback releases it again.
//
//   Optional feature (macro REGFILE_BYPASS_EN):
//     When defined, a write in the current cycle is forwarded combinationally
//     to a read port that selects the same register. The busy bit for that
//     register reads 0 in that cycle, unless it is reserved in the same cycle.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset; restarts the clear engine
//   clr            runtime clear request; honoured only while ready=1
//   we/sel_in/in   write port (enable, select, data)
//   sel_o1/sel_o2  read port selects
//   o1/o2          read data; combinational, forced to 0 while clearing
//   rsv/sel_rsv    reserve request; marks busy[sel_rsv]
//   busy1/busy2    busy bits of sel_o1/sel_o2; forced to 0 while clearing
//   ready          clear finished, file usable
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    sel_in,
  input  logic [WIDTH-1:0] in,
  input  logic [AW-1:0]    sel_o1,
  input  logic [AW-1:0]    sel_o2,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  input  logic             rsv,
  input  logic [AW-1:0]    sel_rsv,
  output logic             busy1,
  output logic             busy2,
  output logic             ready
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [AW-1:0]     ptr;
  logic [DEPTH-1:0]  busy;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              clear_write;
  logic              user_write;

  assign clear_write = !rst && (state == CLEAR);
  assign user_write  = !rst && (state == READY) && !clr && we;

  // Control FSM and scoreboard. When a write and a reservation target the
  // same register on one edge, the reservation is applied last, so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
      busy  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          ptr <= ptr + AW'(1);
          if (ptr == AW'(DEPTH - 1))
            state <= READY;
        end
        READY: begin
          if (clr) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= '0;
          end else begin
            if (we)
              busy[sel_in] <= 1'b0;
            if (rsv)
              busy[sel_rsv] <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
          busy  <= '0;
        end
      endcase
    end
  end

  // Storage has no reset. The clear engine zeroes it, so it stays a plain
  // single-write-port array.
  always_ff @(posedge clk) begin
    if (clear_write)
      mem[ptr] <= '0;
    else if (user_write)
      mem[sel_in] <= in;
  end

  assign ready = (state == READY);

  // Read ports. All outputs are held at 0 until the file is clean, so no X
  // leaks out of storage that has not been cleared yet.
  always_comb begin
    o1    = '0;
    o2    = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (state == READY) begin
      o1    = mem[sel_o1];
      o2    = mem[sel_o2];
      busy1 = busy[sel_o1];
      busy2 = busy[sel_o2];
`ifdef REGFILE_BYPASS_EN
      if (we && (sel_in == sel_o1)) begin
        o1    = in;
        busy1 = rsv && (sel_rsv == sel_o1);
      end
      if (we && (sel_in == sel_o2)) begin
        o2    = in;
        busy2 = rsv && (sel_rsv == sel_o2);
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//   Directed self-checking bench for regfile_mp (WIDTH=8, DEPTH=16).
//   Expected values for the forwarding case follow REGFILE_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       we;
  logic [3:0] sel_in;
  logic [7:0] in;
  logic [3:0] sel_o1;
  logic [3:0] sel_o2;
  logic [7:0] o1;
  logic [7:0] o2;
  logic       rsv;
  logic [3:0] sel_rsv;
  logic       busy1;
  logic       busy2;
  logic       ready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  regfile_mp #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .sel_in(sel_in), .in(in),
    .sel_o1(sel_o1), .sel_o2(sel_o2), .o1(o1), .o2(o2), .rsv(rsv),
    .sel_rsv(sel_rsv), .busy1(busy1), .busy2(busy2), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before anything is sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({ready, busy1, busy2, o1, o2} !== 19'd0) begin
      $display("[TB] FAIL reset_state: got ready=%b busy=%b%b o1=%h o2=%h, need all 0",
               ready, busy1, busy2, o1, o2);
    end else pass_cnt++;
    for (int i = 1; i <= 16; i++) begin
      tick();
      total_cnt++;
      if (ready !== (i == 16)) begin
        $display("[TB] FAIL reset_ready_edge%0d: got %b, need %b", i, ready, (i == 16));
      end else pass_cnt++;
    end
    for (int i = 0; i < 16; i++) begin
      sel_o1 = 4'(i);
      sel_o2 = 4'(15 - i);
      #1;
      total_cnt++;
      if (o1 !== 8'h00 || o2 !== 8'h00) begin
        $display("[TB] FAIL reset_cleared_r%0d: got o1=%h o2=%h, need 00 00", i, o1, o2);
      end else pass_cnt++;
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; sel_in = 4'd3; in = 8'hA5;
    tick();
    sel_in = 4'd7; in = 8'h5A;
    tick();
    we = 1'b0;
    sel_o1 = 4'd3; sel_o2 = 4'd7;
    #1;
    total_cnt++;
    if (o1 !== 8'hA5 || o2 !== 8'h5A) begin
      $display("[TB] FAIL write_read: got o1=%h o2=%h, need a5 5a", o1, o2);
    end else pass_cnt++;
    sel_o1 = 4'd7;
    #1;
    total_cnt++;
    if (o1 !== 8'h5A) begin
      $display("[TB] FAIL read_same_reg: got o1=%h, need 5a", o1);
    end else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    rsv = 1'b1; sel_rsv = 4'd5;
    tick();
    rsv = 1'b0;
    sel_o1 = 4'd5; sel_o2 = 4'd6;
    #1;
    total_cnt++;
    if (busy1 !== 1'b1 || busy2 !== 1'b0) begin
      $display("[TB] FAIL reserve: got busy1=%b busy2=%b, need 1 0", busy1, busy2);
    end else pass_cnt++;
    we = 1'b1; sel_in = 4'd5; in = 8'h11;
    tick();
    we = 1'b0;
    total_cnt++;
    if (busy1 !== 1'b0 || o1 !== 8'h11) begin
      $display("[TB] FAIL release: got busy1=%b o1=%h, need 0 11", busy1, o1);
    end else pass_cnt++;
    we = 1'b1; sel_in = 4'd5; in = 8'h22;
    rsv = 1'b1; sel_rsv = 4'd5;
    tick();
    we = 1'b0; rsv = 1'b0;
    sel_o2 = 4'd5;
    #1;
    total_cnt++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1 || o1 !== 8'h22) begin
      $display("[TB] FAIL rsv_wins: got busy1=%b busy2=%b o1=%h, need 1 1 22",
               busy1, busy2, o1);
    end else pass_cnt++;
  endtask

  task automatic test_runtime_clear();
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; sel_in = 4'(i); in = 8'(i + 1);
      tick();
    end
    we = 1'b0;
    sel_o1 = 4'd9; sel_o2 = 4'd15;
    #1;
    total_cnt++;
    if (o1 !== 8'h0A || o2 !== 8'h10) begin
      $display("[TB] FAIL fill: got o1=%h o2=%h, need 0a 10", o1, o2);
    end else pass_cnt++;
    clr = 1'b1; we = 1'b1; sel_in = 4'd2; in = 8'hFF;
    tick();
    clr = 1'b0; we = 1'b0;
    total_cnt++;
    if (ready !== 1'b0 || o1 !== 8'h00) begin
      $display("[TB] FAIL clr_enter: got ready=%b o1=%h, need 0 00", ready, o1);
    end else pass_cnt++;
    for (int i = 1; i <= 16; i++) begin
      // A write while clearing must be ignored, so r0 must still end up 0.
      we = (i == 5); sel_in = 4'd0; in = 8'h77;
      rsv = (i == 5); sel_rsv = 4'd9;
      tick();
      we = 1'b0; rsv = 1'b0;
      total_cnt++;
      if (ready !== (i == 16)) begin
        $display("[TB] FAIL clr_ready_edge%0d: got %b, need %b", i, ready, (i == 16));
      end else pass_cnt++;
    end
    for (int i = 0; i < 16; i++) begin
      sel_o1 = 4'(i);
      sel_o2 = 4'(i);
      #1;
      total_cnt++;
      if (o1 !== 8'h00 || o2 !== 8'h00 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
        $display("[TB] FAIL clr_r%0d: got o1=%h o2=%h busy=%b%b, need 00 00 00",
                 i, o1, o2, busy1, busy2);
      end else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 1; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      total_cnt++;
      if (ready !== (i == 16)) begin
        $display("[TB] FAIL rst_mid_clear_edge%0d: got %b, need %b", i, ready, (i == 16));
      end else pass_cnt++;
    end
  endtask

  task automatic test_bypass();
    logic [7:0] exp_pre;
    logic       exp_busy_pre;
    // r4 was zeroed by the last clear; reserve it first to see busy forwarding.
    rsv = 1'b1; sel_rsv = 4'd4;
    tick();
    rsv = 1'b0;
`ifdef REGFILE_BYPASS_EN
    exp_pre      = 8'h3C;
    exp_busy_pre = 1'b0;
`else
    exp_pre      = 8'h00;
    exp_busy_pre = 1'b1;
`endif
    we = 1'b1; sel_in = 4'd4; in = 8'h3C; sel_o1 = 4'd4; sel_o2 = 4'd4;
    #1;
    total_cnt++;
    if (o1 !== exp_pre || o2 !== exp_pre || busy1 !== exp_busy_pre) begin
      $display("[TB] FAIL bypass_pre_edge: got o1=%h o2=%h busy1=%b, need %h %h %b",
               o1, o2, busy1, exp_pre, exp_pre, exp_busy_pre);
    end else pass_cnt++;
    tick();
    we = 1'b0;
    total_cnt++;
    if (o1 !== 8'h3C || busy1 !== 1'b0) begin
      $display("[TB] FAIL bypass_post_edge: got o1=%h busy1=%b, need 3c 0", o1, busy1);
    end else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; we = 1'b0; sel_in = '0; in = '0;
    sel_o1 = '0; sel_o2 = '0; rsv = 1'b0; sel_rsv = '0;
    test_reset();
    test_write_read();
    test_scoreboard();
    test_runtime_clear();
    test_reset_mid_clear();
    test_bypass();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
